// File: rtl/movegen_sequencer.sv
// movegen_sequencer
//   Drives one move-generation pass over the 64-square array for the side to
//   move. Own-piece squares are strobed one at a time, in ascending index
//   order, through a one-hot emit_move. The target vector the array returns is
//   captured and then serialised into a (from, to) move stream using a
//   valid/ready handshake.
//
//   Optional build macro: MOVEGEN_SEQ_PROMO_EN. When it is defined, a pawn move
//   to the last rank is emitted as four moves with m_promo = Q, R, B, N
//   (2, 3, 4, 5). When it is undefined, m_promo is tied to 0.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   start, abort       begin a pass (accepted only when idle); cancel a pass
//   i_wtp, i_own       side to move and its occupancy, sampled on start
//   i_pawn             pawn occupancy (either colour), used live
//   emit_move, o_wtp   one-hot source strobe and latched side to move
//   i_target           array target vector, sampled in the emit cycle
//   m_valid/m_ready    move stream handshake
//   m_from, m_to       source and destination square indices
//   m_promo            promotion code (0 = none)
//   busy, done         pass in progress; one-cycle completion pulse
//   move_count         moves accepted this pass (saturating)
module movegen_sequencer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             i_wtp,
  input  logic [63:0]      i_own,
  input  logic [63:0]      i_pawn,
  output logic [63:0]      emit_move,
  output logic             o_wtp,
  input  logic [63:0]      i_target,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [5:0]       m_from,
  output logic [5:0]       m_to,
  output logic [2:0]       m_promo,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] move_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EMIT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        own_q, own_d;
  logic [63:0]        tgt_q, tgt_d;
  logic [63:0]        emit_q, emit_d;
  logic [5:0]         src_q, src_d;
  logic               wtp_q, wtp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         to_idx;
  logic [5:0]         own_idx;
  logic               last_of_dest;

  function automatic logic [5:0] lsb_idx(input logic [63:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int unsigned i = 64; i > 0; i--) begin
      if (v[i-1]) idx = 6'(i - 1);
    end
    return idx;
  endfunction

  assign to_idx  = lsb_idx(tgt_q);
  assign own_idx = lsb_idx(own_q);

`ifdef MOVEGEN_SEQ_PROMO_EN
  logic [1:0] pidx_q, pidx_d;
  logic       is_promo;

  assign is_promo     = i_pawn[src_q] && (wtp_q ? (to_idx >= 6'd56) : (to_idx <= 6'd7));
  // A promotion destination stays pending until its fourth piece code is taken.
  assign last_of_dest = !is_promo || (pidx_q == 2'd3);
  assign m_promo      = (state_q == S_DRAIN && is_promo) ? ({1'b0, pidx_q} + 3'd2) : 3'd0;
`else
  logic unused_pawn;

  assign unused_pawn  = ^i_pawn;
  assign last_of_dest = 1'b1;
  assign m_promo      = 3'd0;
`endif

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    tgt_d   = tgt_q;
    emit_d  = '0;
    src_d   = src_q;
    wtp_d   = wtp_q;
    cnt_d   = cnt_q;
`ifdef MOVEGEN_SEQ_PROMO_EN
    pidx_d  = pidx_q;
`endif
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
`ifdef MOVEGEN_SEQ_PROMO_EN
      pidx_d  = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            own_d   = i_own;
            wtp_d   = i_wtp;
            cnt_d   = '0;
            state_d = S_SELECT;
          end
        end
        S_SELECT: begin
          if (own_q == '0) begin
            state_d = S_DONE;
          end else begin
            src_d   = own_idx;
            own_d   = own_q & (own_q - 64'd1);
            emit_d  = 64'd1 << own_idx;
            state_d = S_EMIT;
          end
        end
        S_EMIT: begin
          tgt_d   = i_target;
          state_d = (i_target != '0) ? S_DRAIN : S_SELECT;
        end
        S_DRAIN: begin
          if (m_ready) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (last_of_dest) begin
              tgt_d = tgt_q & (tgt_q - 64'd1);
`ifdef MOVEGEN_SEQ_PROMO_EN
              pidx_d = '0;
`endif
              if ((tgt_q & (tgt_q - 64'd1)) == '0) state_d = S_SELECT;
            end
`ifdef MOVEGEN_SEQ_PROMO_EN
            else begin
              pidx_d = pidx_q + 2'd1;
            end
`endif
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      tgt_q   <= '0;
      emit_q  <= '0;
      src_q   <= '0;
      wtp_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MOVEGEN_SEQ_PROMO_EN
      pidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      tgt_q   <= tgt_d;
      emit_q  <= emit_d;
      src_q   <= src_d;
      wtp_q   <= wtp_d;
      cnt_q   <= cnt_d;
`ifdef MOVEGEN_SEQ_PROMO_EN
      pidx_q  <= pidx_d;
`endif
    end
  end

  assign emit_move  = emit_q;
  assign o_wtp      = wtp_q;
  assign m_valid    = (state_q == S_DRAIN);
  assign m_from     = src_q;
  assign m_to       = to_idx;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign move_count = cnt_q;

endmodule
